// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Receive-side control for a UART. Handshakes with the bit-level
//            receiver, checks each completed frame for framing and parity
//            errors, buffers good data in a small FIFO, and raises an
//            interrupt while data is waiting or an error flag is set.
// Ports    : clk, rst (async, active-low)
//            rx_en             - receive enable from the control register
//            store             - frame-complete level from the receiver
//            rx_data[10:0]     - raw frame {stop, parity, data[7:0], start}
//            clr_rx_start_bit  - receiver request to drop rx_start
//            pop               - read strobe for the FIFO head
//            err_clr           - pulse that clears all sticky error flags
//            rx_start          - start-receive command to the receiver
//            rd_data[7:0]      - FIFO head (0 when empty)
//            fifo_empty/full, fifo_count[4:0]
//            parity_err, frame_err, overrun_err - sticky error flags
//            irq               - registered interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int DEPTH      = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        store,
  input  logic [10:0] rx_data,
  input  logic        clr_rx_start_bit,
  input  logic        pop,
  input  logic        err_clr,
  output logic        rx_start,
  output logic [7:0]  rd_data,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [4:0]  fifo_count,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        irq
);

  localparam int         c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_depth = 5'(DEPTH);
  localparam logic       c_odd   = 1'(ODD_PARITY);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_arm     = 3'd1;
  localparam logic [2:0] c_wait    = 3'd2;
  localparam logic [2:0] c_check   = 3'd3;
  localparam logic [2:0] c_release = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            rx_start_q, rx_start_d;
  logic [10:0]     frame_q, frame_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic            irq_q, irq_d;

  logic w_in_check, w_frame_bad, w_par_bad, w_push_req;
  logic w_empty, w_full, w_pop_ok, w_push_ok, w_overrun;

  // Control FSM. The frame is captured on the WAIT->CHECK edge so the
  // evaluation in CHECK is independent of what the receiver does next.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    case (state_q)
      c_idle:    if (rx_en) state_d = c_arm;
      c_arm:     state_d = c_wait;
      c_wait: begin
        if (store) begin
          state_d = c_check;
          frame_d = rx_data;
        end
      end
      c_check:   state_d = c_release;
      c_release: if (clr_rx_start_bit) state_d = c_idle;
      default:   state_d = c_idle;
    endcase
    // Registered from the next state so rx_start tracks "not IDLE" exactly.
    rx_start_d = (state_d != c_idle);
  end

  // Frame evaluation; only meaningful during the single CHECK cycle.
  assign w_in_check  = (state_q == c_check);
  assign w_frame_bad = frame_q[0] | ~frame_q[10];
  assign w_par_bad   = ((^frame_q[9:1]) != c_odd);
  assign w_push_req  = w_in_check & ~w_frame_bad;

  assign w_empty   = (count_q == 5'd0);
  assign w_full    = (count_q == c_depth);
  assign w_pop_ok  = pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok = w_push_req & (~w_full | w_pop_ok);
  assign w_overrun = w_push_req & w_full & ~w_pop_ok;

  always_comb begin
    mem_d = mem_q;
    if (w_push_ok) mem_d[wr_ptr_q] = frame_q[8:1];
    wr_ptr_d = wr_ptr_q + c_aw'(w_push_ok);
    rd_ptr_d = rd_ptr_q + c_aw'(w_pop_ok);
    count_d  = count_q + 5'(w_push_ok) - 5'(w_pop_ok);

    // Clear first, then set: a coincident new error wins over err_clr.
    parity_err_d  = (parity_err_q  & ~err_clr) | (w_push_req & w_par_bad);
    frame_err_d   = (frame_err_q   & ~err_clr) | (w_in_check & w_frame_bad);
    overrun_err_d = (overrun_err_q & ~err_clr) | w_overrun;

    irq_d = (~w_empty | parity_err_q | frame_err_q | overrun_err_q) & rx_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= c_idle;
      rx_start_q    <= 1'b0;
      frame_q       <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_start_q    <= rx_start_d;
      frame_q       <= frame_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      irq_q         <= irq_d;
    end
  end

  assign rx_start    = rx_start_q;
  assign rd_data     = w_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_empty  = w_empty;
  assign fifo_full   = w_full;
  assign fifo_count  = count_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl (DEPTH=4, even parity).
//            A queue-based reference model tracks FIFO contents and the
//            sticky error flags frame by frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int ODD   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en, store, clr_rx_start_bit, pop, err_clr;
  logic [10:0] rx_data;
  logic        rx_start, fifo_empty, fifo_full;
  logic [7:0]  rd_data;
  logic [4:0]  fifo_count;
  logic        parity_err, frame_err, overrun_err, irq;

  uart_rx_ctrl #(.DEPTH(DEPTH), .ODD_PARITY(ODD)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_en            (rx_en),
    .store            (store),
    .rx_data          (rx_data),
    .clr_rx_start_bit (clr_rx_start_bit),
    .pop              (pop),
    .err_clr          (err_clr),
    .rx_start         (rx_start),
    .rd_data          (rd_data),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_count       (fifo_count),
    .parity_err       (parity_err),
    .frame_err        (frame_err),
    .overrun_err      (overrun_err),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q_m [$];
  logic       pe_m, fe_m, oe_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_irq();
    return ((q_m.size() != 0) | pe_m | fe_m | oe_m) & rx_en;
  endfunction

  function automatic logic [7:0] exp_head();
    return (q_m.size() != 0) ? q_m[0] : 8'h00;
  endfunction

  // kind: 0 good, 1 parity error, 2 bad start bit, 3 bad stop bit
  function automatic logic [10:0] mk(input logic [7:0] d, input int kind);
    logic p, st, sp;
    p  = (^d) ^ 1'(ODD);
    st = 1'b0;
    sp = 1'b1;
    if (kind == 1) p  = ~p;
    if (kind == 2) st = 1'b1;
    if (kind == 3) sp = 1'b0;
    return {sp, p, d, st};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_cnt"},   32'(fifo_count),  32'(q_m.size()));
    chk({tag, "_head"},  32'(rd_data),     32'(exp_head()));
    chk({tag, "_empty"}, 32'(fifo_empty),  32'(q_m.size() == 0));
    chk({tag, "_full"},  32'(fifo_full),   32'(q_m.size() == DEPTH));
    chk({tag, "_pe"},    32'(parity_err),  32'(pe_m));
    chk({tag, "_fe"},    32'(frame_err),   32'(fe_m));
    chk({tag, "_oe"},    32'(overrun_err), 32'(oe_m));
  endtask

  task automatic wait_rx_start();
    int n = 0;
    while (rx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arm_timeout", 32'(rx_start), 32'd1);
  endtask

  // One complete receiver handshake. Store is raised while the controller
  // waits; pop/err_clr (if requested) land in the evaluation cycle.
  task automatic send_frame(input logic [10:0] f, input bit pop_c,
                            input bit clr_c, input bit drop_en);
    logic pre_irq, fbad, pbad, popped, was_full;
    wait_rx_start();
    @(negedge clk);
    rx_data = f;
    store   = 1'b1;
    if (drop_en) rx_en = 1'b0;
    @(negedge clk);
    pre_irq = exp_irq();
    if (pop_c && q_m.size() != 0) chk("pop_head", 32'(rd_data), 32'(q_m[0]));
    pop     = pop_c;
    err_clr = clr_c;
    @(negedge clk);
    pop     = 1'b0;
    err_clr = 1'b0;
    fbad     = (f[0] != 1'b0) || (f[10] != 1'b1);
    pbad     = ((^f[9:1]) != 1'(ODD));
    was_full = (q_m.size() == DEPTH);
    popped   = 1'b0;
    if (clr_c) begin
      pe_m = 1'b0; fe_m = 1'b0; oe_m = 1'b0;
    end
    if (pop_c && q_m.size() != 0) begin
      void'(q_m.pop_front());
      popped = 1'b1;
    end
    if (fbad) fe_m = 1'b1;
    else begin
      if (pbad) pe_m = 1'b1;
      if (was_full && !popped) oe_m = 1'b1;
      else q_m.push_back(f[8:1]);
    end
    check_state("frame");
    chk("irq_pre", 32'(irq), 32'(pre_irq));
    @(negedge clk);
    chk("irq_post", 32'(irq), 32'(exp_irq()));
    repeat (3) @(negedge clk);
    chk("rx_start_hold", 32'(rx_start), 32'd1);
    store            = 1'b0;
    clr_rx_start_bit = 1'b1;
    @(negedge clk);
    clr_rx_start_bit = 1'b0;
    chk("rx_start_drop", 32'(rx_start), 32'd0);
    check_state("post");
    if (drop_en) begin
      repeat (3) @(negedge clk);
      chk("no_rearm", 32'(rx_start), 32'd0);
    end
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (q_m.size() != 0) void'(q_m.pop_front());
    check_state("pop");
  endtask

  task automatic do_errclr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    pe_m = 1'b0; fe_m = 1'b0; oe_m = 1'b0;
    check_state("errclr");
  endtask

  // Asynchronous reset applied mid-cycle, outputs checked before any edge.
  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    q_m.delete();
    pe_m = 1'b0; fe_m = 1'b0; oe_m = 1'b0;
    check_state(tag);
    chk({tag, "_rxs"}, 32'(rx_start), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    store = 1'b0; pop = 1'b0; err_clr = 1'b0; clr_rx_start_bit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rx_en = 1'b0; store = 1'b0; clr_rx_start_bit = 1'b0;
    pop = 1'b0; err_clr = 1'b0; rx_data = '0;
    pe_m = 1'b0; fe_m = 1'b0; oe_m = 1'b0;
    @(negedge clk);
    apply_reset("rst0");

    // Stays idle until rx_en, then arms on the next edge
    repeat (3) @(negedge clk);
    chk("idle_no_en", 32'(rx_start), 32'd0);
    rx_en = 1'b1;
    @(negedge clk);
    chk("arm_after_en", 32'(rx_start), 32'd1);

    // Good frame 0xA5
    send_frame(11'b1_0_10100101_0, 1'b0, 1'b0, 1'b0);
    chk("good_a5", 32'(rd_data), 32'h0A5);
    do_pop();
    do_pop();  // pop while empty is ignored

    // Framing error (stop bit 0), then clear
    send_frame(11'b0_0_10100101_0, 1'b0, 1'b0, 1'b0);
    do_errclr();

    // Parity error on data 0x01
    send_frame(mk(8'h01, 1), 1'b0, 1'b0, 1'b0);
    chk("par_data", 32'(rd_data), 32'h01);
    do_pop();
    do_errclr();

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(mk(8'(8'h10 + i), 0), 1'b0, 1'b0, 1'b0);
    send_frame(mk(8'h77, 0), 1'b1, 1'b0, 1'b0);  // full + pop: no new overrun
    send_frame(mk(8'h3C, 1), 1'b1, 1'b1, 1'b0);  // err_clr coincides with parity error
    for (int i = 0; i < 4; i++) do_pop();
    send_frame(mk(8'h5A, 0), 1'b1, 1'b0, 1'b0);  // push + pop while empty
    do_errclr();

    // rx_en dropped mid-frame: frame completes, no re-arm
    send_frame(mk(8'hC3, 0), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rx_en = 1'b1;

    // Reset in WAIT
    wait_rx_start();
    @(negedge clk);
    apply_reset("rst_wait");

    // Reset in CHECK with data already buffered and a flag set
    send_frame(mk(8'h99, 1), 1'b0, 1'b0, 1'b0);
    wait_rx_start();
    @(negedge clk);
    rx_data = mk(8'h42, 0);
    store   = 1'b1;
    @(negedge clk);
    rx_en = 1'b0;
    apply_reset("rst_check");
    repeat (3) @(negedge clk);
    check_state("after_rst");
    chk("rst_no_arm", 32'(rx_start), 32'd0);
    rx_en = 1'b1;

    // Randomized frames, pops and clears
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind <= 2) kind = 0;
      else kind = kind - 2;
      send_frame(mk(8'($urandom), kind), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0) do_pop();
      if ($urandom_range(0, 9) == 0) do_errclr();
    end
    while (q_m.size() != 0) do_pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
